// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode constants, the command
// type, the request record and the requester count.
package alu_pkg;

  localparam int NPORT    = 2;
  localparam int ALU_TAGW = 2;

  typedef logic [4:0] alu_cmd_t;

  // Opcodes are carried through unchanged; the ALU owns their meaning.
  localparam alu_cmd_t OP_NOP = 5'b00000;
  localparam alu_cmd_t OP_MOV = 5'b00001;
  localparam alu_cmd_t OP_ADD = 5'b01000;
  localparam alu_cmd_t OP_SUB = 5'b01001;
  localparam alu_cmd_t OP_AND = 5'b01010;
  localparam alu_cmd_t OP_OR  = 5'b01011;
  localparam alu_cmd_t OP_BEQ = 5'b11000;

  typedef struct packed {
    alu_cmd_t            cmd;
    logic [7:0]          a;
    logic [7:0]          b;
    logic [ALU_TAGW-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter with one-hot grant. With ALU_ARB_RR_EN defined it is
// round-robin on a 1-bit pointer; otherwise port 0 has fixed priority.
module rr_arbiter2 (
`ifdef ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Pointer moves to the port after the winner, only when something is granted.
  always_ff @(posedge clk) begin
    if (reset)       ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req[0])      grant = 2'b01;
    else if (req[1]) grant = 2'b10;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters through a registered
// issue stage and per-port one-entry response buffers. Macro: ALU_ARB_RR_EN.
module alu_arbiter #(
  parameter int NPORT = alu_pkg::NPORT,
  parameter int TAGW  = alu_pkg::ALU_TAGW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORT-1:0]           req_valid,
  output logic [NPORT-1:0]           req_ready,
  input  logic [NPORT-1:0][4:0]      req_cmd,
  input  logic [NPORT-1:0][7:0]      req_a,
  input  logic [NPORT-1:0][7:0]      req_b,
  input  logic [NPORT-1:0][TAGW-1:0] req_tag,
  output logic [NPORT-1:0]           rsp_valid,
  input  logic [NPORT-1:0]           rsp_ready,
  output logic [NPORT-1:0][7:0]      rsp_data,
  output logic [NPORT-1:0]           rsp_branch,
  output logic [NPORT-1:0][TAGW-1:0] rsp_tag,
  output logic [4:0]                 alu_cmd,
  output logic [7:0]                 alu_inA,
  output logic [7:0]                 alu_inB,
  input  logic [7:0]                 alu_rslt,
  input  logic                       alu_doBranch
);
  import alu_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a request must hold its fields until accepted, and a response
  // holds its fields until consumed.

  logic             iss_v;
  logic             iss_port;
  alu_req_t         iss;
  logic [1:0]       in_flight;
  logic [1:0]       eligible;
  logic [1:0]       arb_grant;
  logic [1:0]       grant;

  assign in_flight = {iss_v & iss_port, iss_v & ~iss_port};

  // A port may issue only when it has nothing in flight and its buffer will
  // have room by the time the result lands.
  assign eligible = req_valid & ~in_flight & (~rsp_valid | rsp_ready);

  rr_arbiter2 u_arb (
`ifdef ALU_ARB_RR_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   (eligible),
    .grant (arb_grant)
  );

  assign grant     = reset ? 2'b00 : arb_grant;
  assign req_ready = grant;

  // Idle cycles load zeros so the ALU sees NOP with zero operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_v    <= 1'b0;
      iss_port <= 1'b0;
      iss      <= '0;
    end else begin
      iss_v    <= |grant;
      iss_port <= grant[1];
      if (grant[1])
        iss <= '{cmd: req_cmd[1], a: req_a[1], b: req_b[1], tag: req_tag[1]};
      else if (grant[0])
        iss <= '{cmd: req_cmd[0], a: req_a[0], b: req_b[0], tag: req_tag[0]};
      else
        iss <= '0;
    end
  end

  assign alu_cmd = iss.cmd;
  assign alu_inA = iss.a;
  assign alu_inB = iss.b;

  // A capture in the same cycle as a drain wins, keeping the buffer full.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_branch <= '0;
      rsp_tag    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_flight[i]) begin
          rsp_valid[i]  <= 1'b1;
          rsp_data[i]   <= alu_rslt;
          rsp_branch[i] <= alu_doBranch;
          rsp_tag[i]    <= iss.tag;
        end else if (rsp_ready[i]) begin
          rsp_valid[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single ops plus hand-written
// contention, backpressure and reset-mid-op sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TAGW = 2;
`ifdef ALU_ARB_RR_EN
  localparam logic [1:0] EXP_PRIO = 2'b10;
`else
  localparam logic [1:0] EXP_PRIO = 2'b01;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid, req_ready, rsp_valid, rsp_ready, rsp_branch;
  logic [1:0][4:0]       req_cmd;
  logic [1:0][7:0]       req_a, req_b, rsp_data;
  logic [1:0][TAGW-1:0]  req_tag, rsp_tag;
  logic [4:0]            alu_cmd;
  logic [7:0]            alu_inA, alu_inB, alu_rslt;
  logic                  alu_doBranch;
  logic                  force_branch;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int         port;
    logic [4:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] tag;
    logic       fb;
    logic [7:0] exp_data;
    logic       exp_br;
  } vec_t;

  vec_t vecs[9];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  alu_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_branch   (rsp_branch),
    .rsp_tag      (rsp_tag),
    .alu_cmd      (alu_cmd),
    .alu_inA      (alu_inA),
    .alu_inB      (alu_inB),
    .alu_rslt     (alu_rslt),
    .alu_doBranch (alu_doBranch)
  );

  // external ALU stand-in
  always_comb begin
    alu_rslt = 8'h00;
    case (alu_cmd)
      OP_ADD:  alu_rslt = alu_inA + alu_inB;
      OP_SUB:  alu_rslt = alu_inA - alu_inB;
      OP_MOV:  alu_rslt = alu_inA;
      OP_AND:  alu_rslt = alu_inA & alu_inB;
      OP_OR:   alu_rslt = alu_inA | alu_inB;
      default: alu_rslt = 8'h00;
    endcase
    alu_doBranch = force_branch | ((alu_cmd == OP_BEQ) && (alu_inA == alu_inB));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    req_cmd[v.port]   = v.cmd;
    req_a[v.port]     = v.a;
    req_b[v.port]     = v.b;
    req_tag[v.port]   = v.tag;
    req_valid[v.port] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[v.port] && n < 10) begin
      tick();
      #1;
      n++;
    end
    chk("op_req_ready", req_ready[v.port], 1'b1);
    tick();
    req_valid[v.port] = 1'b0;
    force_branch = v.fb;
    #1;
    chk("op_alu_cmd", alu_cmd, v.cmd);
    chk("op_alu_inA", alu_inA, v.a);
    chk("op_alu_inB", alu_inB, v.b);
    tick();
    force_branch = 1'b0;
    chk("op_rsp_valid", rsp_valid[v.port], 1'b1);
    chk("op_rsp_data", rsp_data[v.port], v.exp_data);
    chk("op_rsp_tag", rsp_tag[v.port], v.tag);
    chk("op_rsp_branch", rsp_branch[v.port], v.exp_br);
    rsp_ready[v.port] = 1'b1;
    tick();
    rsp_ready[v.port] = 1'b0;
    chk("op_rsp_drained", rsp_valid[v.port], 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, OP_ADD,   8'h05, 8'h03, 2'd1, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{1, OP_SUB,   8'h10, 8'h01, 2'd2, 1'b0, 8'h0F, 1'b0};
    vecs[2] = '{0, OP_MOV,   8'h5A, 8'h00, 2'd3, 1'b0, 8'h5A, 1'b0};
    vecs[3] = '{1, OP_ADD,   8'hFF, 8'h02, 2'd0, 1'b0, 8'h01, 1'b0};
    vecs[4] = '{0, 5'b10000, 8'hFF, 8'h00, 2'd2, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1, OP_BEQ,   8'h33, 8'h33, 2'd1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{0, OP_AND,   8'hF0, 8'h3C, 2'd0, 1'b1, 8'h30, 1'b1};
    vecs[7] = '{0, OP_ADD,   8'h01, 8'h01, 2'd3, 1'b0, 8'h02, 1'b0};
    vecs[8] = '{1, OP_OR,    8'h0F, 8'hF0, 2'd2, 1'b0, 8'hFF, 1'b0};

    reset        = 1'b1;
    force_branch = 1'b0;
    rsp_ready    = 2'b00;
    req_valid    = 2'b11;
    req_cmd      = {OP_ADD, OP_ADD};
    req_a        = {8'h11, 8'h22};
    req_b        = {8'h33, 8'h44};
    req_tag      = {2'd1, 2'd2};
    tick();
    for (int c = 0; c < 2; c++) begin
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_alu_cmd", alu_cmd, 5'b00000);
      chk("rst_alu_inA", alu_inA, 8'h00);
      chk("rst_alu_inB", alu_inB, 8'h00);
      tick();
    end
    reset     = 1'b0;
    req_valid = 2'b00;
    tick();

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // contention: both ports hold SUB 0x10,0x01
    rsp_ready = 2'b11;
    req_cmd   = {OP_SUB, OP_SUB};
    req_a     = {8'h10, 8'h10};
    req_b     = {8'h01, 8'h01};
    req_tag   = {2'd2, 2'd1};
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      #1;
      e = exp_q.pop_front();
      chk("contend_grant", req_ready, e);
      if (rsp_valid[0]) chk("contend_rsp0", rsp_data[0], 8'h0F);
      if (rsp_valid[1]) chk("contend_rsp1", rsp_data[1], 8'h0F);
      tick();
    end
    req_valid = 2'b00;
    tick(); tick(); tick();
    chk("contend_drained", rsp_valid, 2'b00);

    // arbitration policy once p0 was the last winner
    req_valid = 2'b01;
    #1;
    chk("prio_solo", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b11;
    #1;
    chk("prio_both", req_ready, EXP_PRIO);
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();

    // backpressure on port 0 while port 1 streams
    rsp_ready  = 2'b10;
    req_cmd[0] = OP_ADD;
    req_a[0]   = 8'h20;
    req_b[0]   = 8'h22;
    req_tag[0] = 2'd3;
    req_valid  = 2'b01;
    #1;
    chk("bp_grant0", req_ready, 2'b01);
    tick();
    req_valid  = 2'b00;
    req_a[0]   = 8'h01;
    req_b[0]   = 8'h01;
    req_tag[0] = 2'd0;
    tick();
    req_valid  = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bp_ready", req_ready, (k % 2 == 0) ? 2'b10 : 2'b00);
      chk("bp_hold_valid", rsp_valid[0], 1'b1);
      chk("bp_hold_data", rsp_data[0], 8'h42);
      chk("bp_hold_tag", rsp_tag[0], 2'd3);
      tick();
    end
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1;
    chk("bp_release", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    chk("bp_alu_cmd", alu_cmd, OP_ADD);
    chk("bp_alu_inA", alu_inA, 8'h01);
    tick();
    chk("bp_rsp_valid", rsp_valid[0], 1'b1);
    chk("bp_rsp_data", rsp_data[0], 8'h02);
    chk("bp_rsp_tag", rsp_tag[0], 2'd0);
    tick();
    rsp_ready = 2'b00;

    // reset one cycle after a grant discards the op
    req_cmd[0] = OP_ADD;
    req_a[0]   = 8'h07;
    req_b[0]   = 8'h07;
    req_tag[0] = 2'd2;
    req_valid  = 2'b01;
    #1;
    chk("rm_grant", req_ready, 2'b01);
    tick();
    reset     = 1'b1;
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    chk("rm_no_rsp", rsp_valid, 2'b00);
    chk("rm_alu_idle", alu_cmd, 5'b00000);
    tick();
    chk("rm_no_rsp_late", rsp_valid, 2'b00);
    run_op('{0, OP_MOV, 8'h77, 8'h00, 2'd1, 1'b0, 8'h77, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
